sample_accum_decim: RTL and testbench



---
 rtl/sample_accum_pkg.sv | 36 +++
 rtl/sample_accum_decim_if.sv | 24 ++
 rtl/sample_hold_reg.sv | 39 +++
 rtl/sample_accum_decim.sv | 73 +++++++
 tb/tb_sample_accum_decim.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sample_accum_pkg.sv
// Shared constants and the scale/saturate helper for sample_accum_decim.
// SAMPLE_ACCUM_ROUND_EN selects round-half-up ahead of the shift.
package sample_accum_pkg;

    localparam int SAMPLE_W   = 32;
    localparam int DROP_CNT_W = 8;
    localparam int SUM_MAX_W  = 64;

    // Callers sign-extend their sum to SUM_MAX_W bits.
    // The extra top bit keeps the rounding add from wrapping.
    function automatic logic signed [SAMPLE_W-1:0] sat_shift(
        input logic signed [SUM_MAX_W-1:0] sum,
        input int                          shift
    );
        logic signed [SUM_MAX_W:0] ext;
        logic signed [SUM_MAX_W:0] shf;
        logic signed [SUM_MAX_W:0] max_v;
        logic signed [SUM_MAX_W:0] min_v;
        max_v = 65'sd2147483647;
        min_v = -65'sd2147483648;
        ext   = {sum[SUM_MAX_W-1], sum};
`ifdef SAMPLE_ACCUM_ROUND_EN
        if (shift > 0) begin
            ext = ext + (65'sd1 <<< (shift - 1));
        end
`endif
        shf = ext >>> shift;
        if (shf > max_v) begin
            return max_v[SAMPLE_W-1:0];
        end else if (shf < min_v) begin
            return min_v[SAMPLE_W-1:0];
        end
        return shf[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_accum_decim_if.sv
// Sample-in / result-out bundle of sample_accum_decim.
// The slave modport is the decimator side; the master modport is its environment.
interface sample_accum_decim_if;
    import sample_accum_pkg::*;

    logic signed [SAMPLE_W-1:0]   in_data;
    logic                         in_valid;
    logic signed [SAMPLE_W-1:0]   out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         overrun;
    logic        [DROP_CNT_W-1:0] drop_cnt;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, overrun, drop_cnt
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, overrun, drop_cnt
    );

endinterface

// File: rtl/sample_hold_reg.sv
// One-entry valid/ready holding register.
// A load arriving while full and not being drained is reported on o_dropped.
module sample_hold_reg
    import sample_accum_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic signed [SAMPLE_W-1:0] i_data,
    output logic signed [SAMPLE_W-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_dropped
);

    logic signed [SAMPLE_W-1:0] r_data_p1;
    logic                       r_vld_p1;
    logic                       w_accept;

    // The slot can take a new result when empty or when being drained this cycle.
    assign w_accept  = !r_vld_p1 || i_ready;
    assign o_dropped = i_load && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else if (i_load && w_accept) begin
            r_data_p1 <= i_data;
            r_vld_p1  <= 1'b1;
        end else if (r_vld_p1 && i_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign o_data  = r_data_p1;
    assign o_valid = r_vld_p1;

endmodule

// File: rtl/sample_accum_decim.sv
// Integrate-and-dump decimator: sums DECIM samples, shifts, saturates to 32 bits.
// Define SAMPLE_ACCUM_ROUND_EN for round-half-up before the shift. ACC_W must be <= 64.
module sample_accum_decim
    import sample_accum_pkg::*;
#(
    parameter int DECIM = 8,
    parameter int SHIFT = 3,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    sample_accum_decim_if.slave  bus
);

    localparam int CNT_W = $clog2(DECIM);

    logic signed [ACC_W-1:0]      r_acc_p0;
    logic        [CNT_W-1:0]      r_cnt_p0;
    logic signed [ACC_W-1:0]      w_sum_next;
    logic signed [SAMPLE_W-1:0]   w_result;
    logic                         w_dump;
    logic                         w_dropped;
    logic                         r_overrun;
    logic        [DROP_CNT_W-1:0] r_drop_cnt;

    // Stage 0: accumulate; the DECIM-th sample is folded into its own block.
    assign w_sum_next = r_acc_p0 + ACC_W'(bus.in_data);
    assign w_dump     = bus.in_valid && (r_cnt_p0 == CNT_W'(DECIM - 1));
    assign w_result   = sat_shift(SUM_MAX_W'(w_sum_next), SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p0 <= '0;
            r_cnt_p0 <= '0;
        end else if (bus.in_valid) begin
            if (w_dump) begin
                r_acc_p0 <= '0;
                r_cnt_p0 <= '0;
            end else begin
                r_acc_p0 <= w_sum_next;
                r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
            end
        end
    end

    // Stage 1: result holding register.
    sample_hold_reg u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_dump),
        .i_data    (w_result),
        .o_data    (bus.out_data),
        .o_valid   (bus.out_valid),
        .i_ready   (bus.out_ready),
        .o_dropped (w_dropped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_dropped) begin
            r_overrun <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    assign bus.overrun  = r_overrun;
    assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_sample_accum_decim.sv
// Directed bench for sample_accum_decim: DECIM=4 with SHIFT=2 (u_a) and SHIFT=0 (u_b),
// both fed the same stimulus; results are scoreboarded against a longint model.
module tb_sample_accum_decim;

    logic clk;
    logic rst;

    sample_accum_decim_if if_a();
    sample_accum_decim_if if_b();

    sample_accum_decim #(.DECIM(4), .SHIFT(2), .ACC_W(40)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    sample_accum_decim #(.DECIM(4), .SHIFT(0), .ACC_W(40)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_hs_a   = 0;
    int n_hs_b   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    longint      m_acc = 0;
    int          m_cnt = 0;

`ifdef SAMPLE_ACCUM_ROUND_EN
    localparam logic [31:0] EXP_T1_A = 32'd3;
`else
    localparam logic [31:0] EXP_T1_A = 32'd2;
`endif

    function automatic logic [31:0] model(input longint s, input int sh);
        longint r;
        longint hi;
        longint lo;
        hi = 64'sd2147483647;
        lo = -64'sd2147483648;
        r  = s;
`ifdef SAMPLE_ACCUM_ROUND_EN
        if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
`endif
        r = r >>> sh;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        if_a.out_ready = r;
        if_b.out_ready = r;
    endtask

    // Drive one cycle; on the 4th valid sample push both expected results.
    task automatic drive(input logic signed [31:0] d, input logic v);
        if_a.in_data  = d;
        if_b.in_data  = d;
        if_a.in_valid = v;
        if_b.in_valid = v;
        if (v) begin
            m_acc = m_acc + longint'(d);
            m_cnt = m_cnt + 1;
            if (m_cnt == 4) begin
                q_a.push_back(model(m_acc, 2));
                q_b.push_back(model(m_acc, 0));
                m_acc = 0;
                m_cnt = 0;
            end
        end
        tick();
    endtask

    // Scoreboard: a handshake happens at the next rising edge when valid && ready now.
    always @(negedge clk) begin
        if (!rst && if_a.out_valid && if_a.out_ready) begin
            n_hs_a++;
            n_assert++;
            assert (q_a.size() != 0) else begin
                n_fail++;
                $error("FAIL a_spurious observed=%h expected=none", if_a.out_data);
            end
            if (q_a.size() != 0) chk("a_data", if_a.out_data, q_a.pop_front());
        end
        if (!rst && if_b.out_valid && if_b.out_ready) begin
            n_hs_b++;
            n_assert++;
            assert (q_b.size() != 0) else begin
                n_fail++;
                $error("FAIL b_spurious observed=%h expected=none", if_b.out_data);
            end
            if (q_b.size() != 0) chk("b_data", if_b.out_data, q_b.pop_front());
        end
    end

    int hs_mark;

    initial begin
        rst = 1'b1;
        set_ready(1'b1);
        if_a.in_data = '0;  if_b.in_data = '0;
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, if_b.out_valid}, 32'd0);
        chk("rst_data", if_b.out_data, 32'd0);
        chk("rst_overrun", {31'd0, if_b.overrun}, 32'd0);
        chk("rst_dropcnt", {24'd0, if_b.drop_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Ramp 1..4 with out_ready high.
        drive(1, 1); drive(2, 1); drive(3, 1);
        chk("t1_not_yet", {31'd0, if_a.out_valid}, 32'd0);
        drive(4, 1);
        chk("t1_valid", {31'd0, if_a.out_valid}, 32'd1);
        chk("t1_a", if_a.out_data, EXP_T1_A);
        chk("t1_b", if_b.out_data, 32'd10);
        drive(0, 0);
        chk("t1_drained", {31'd0, if_a.out_valid}, 32'd0);

        // Negative samples, then a gapped valid pattern.
        repeat (4) drive(-1, 1);
        chk("t2_a", if_a.out_data, 32'hFFFF_FFFF);
        drive(0, 0);
        drive(-1, 1); drive(-1, 0); drive(-1, 0); drive(-1, 1); drive(-1, 1); drive(-1, 0);
        chk("t2_gap_wait", {31'd0, if_a.out_valid}, 32'd0);
        drive(-1, 1);
        chk("t2_gap_valid", {31'd0, if_a.out_valid}, 32'd1);
        chk("t2_gap_a", if_a.out_data, 32'hFFFF_FFFF);
        drive(0, 0);

        // Saturation at both rails.
        repeat (4) drive(32'sh7FFF_FFFF, 1);
        chk("t3_pos_b", if_b.out_data, 32'h7FFF_FFFF);
        drive(0, 0);
        repeat (4) drive(32'sh8000_0000, 1);
        chk("t3_neg_b", if_b.out_data, 32'h8000_0000);
        drive(0, 0);

        // Overrun: two blocks with out_ready low; the second is dropped.
        set_ready(1'b0);
        drive(1, 1); drive(2, 1); drive(3, 1); drive(4, 1);
        chk("t4_ovr_before", {31'd0, if_b.overrun}, 32'd0);
        drive(5, 1); drive(6, 1); drive(7, 1); drive(8, 1);
        void'(q_a.pop_back());
        void'(q_b.pop_back());
        chk("t4_hold_valid", {31'd0, if_b.out_valid}, 32'd1);
        chk("t4_hold_data", if_b.out_data, 32'd10);
        chk("t4_overrun", {31'd0, if_b.overrun}, 32'd1);
        chk("t4_dropcnt", {24'd0, if_b.drop_cnt}, 32'd1);
        set_ready(1'b1);
        drive(0, 0);
        chk("t4_drained", {31'd0, if_b.out_valid}, 32'd0);
        chk("t4_sticky", {31'd0, if_b.overrun}, 32'd1);

        // Dump in the same cycle as a handshake.
        set_ready(1'b0);
        repeat (4) drive(1, 1);
        drive(2, 1); drive(2, 1); drive(2, 1);
        set_ready(1'b1);
        drive(2, 1);
        chk("t5_valid", {31'd0, if_b.out_valid}, 32'd1);
        chk("t5_b", if_b.out_data, 32'd8);
        chk("t5_no_drop", {24'd0, if_b.drop_cnt}, 32'd1);
        drive(0, 0);

        // Reset mid-block discards the partial sum.
        drive(1, 1); drive(1, 1);
        rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        drive(0, 0);
        rst = 1'b0;
        chk("t6_valid", {31'd0, if_b.out_valid}, 32'd0);
        chk("t6_data", if_b.out_data, 32'd0);
        chk("t6_overrun", {31'd0, if_b.overrun}, 32'd0);
        chk("t6_dropcnt", {24'd0, if_b.drop_cnt}, 32'd0);
        hs_mark = n_hs_b;
        repeat (4) drive(1, 1);
        chk("t6_b", if_b.out_data, 32'd4);
        repeat (3) drive(0, 0);
        chk("t6_one_result", n_hs_b - hs_mark, 32'd1);

        chk("end_q_a", q_a.size(), 32'd0);
        chk("end_q_b", q_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
